// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter that funnels N requesters into one FIFO write port.
// Optional per-requester accepted-beat counters are enabled with `define FIFO_WR_ARB_BEATCNT_EN.
module fifo_wr_arbiter #(
   parameter int B = 8,
   parameter int N = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     last,
   input  logic [N*B-1:0]   w_data_in,
   output logic [N-1:0]     gnt,
   output logic [N-1:0]     ack,
   input  logic             fifo_full,
   output logic             fifo_wr,
   output logic [B-1:0]     fifo_w_data,
`ifdef FIFO_WR_ARB_BEATCNT_EN
   output logic [N*16-1:0]  beat_cnt,
`endif
   output logic             busy
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_LOCK = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [N-1:0]    r_gnt;
   logic [N-1:0]    w_gnt_nxt;
   logic [PW-1:0]   r_rr_ptr;
   logic [PW-1:0]   w_rr_nxt;
   logic [PW-1:0]   r_gidx;
   logic [PW-1:0]   w_gidx_nxt;
   logic [PW-1:0]   w_gidx_inc;
   logic [PW-1:0]   w_sel;
   logic            w_found;
   logic [B-1:0]    w_data;

   // Round-robin search: walk from rr_ptr downward-in-priority so the closest requester wins last.
   always_comb begin
      int            j;
      logic [PW-1:0] jw;
      w_found = 1'b0;
      w_sel   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(r_rr_ptr) + k;
         if (j >= N) begin
            j = j - N;
         end else begin
            j = j;
         end
         jw      = PW'(j);
         w_sel   = req[jw] ? jw : w_sel;
         w_found = w_found | req[jw];
      end
   end

   // Pointer for the requester after the current owner, wrapping at N.
   always_comb begin
      if (r_gidx == PW'(N - 1)) begin
         w_gidx_inc = '0;
      end else begin
         w_gidx_inc = r_gidx + PW'(1);
      end
   end

   // Next-state logic: grant on request in IDLE, release on the accepted last beat in LOCK.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_gidx_nxt  = r_gidx;
      w_rr_nxt    = r_rr_ptr;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_LOCK;
               w_gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << w_sel;
               w_gidx_nxt  = w_sel;
            end else begin
               w_gnt_nxt   = '0;
            end
         end
         S_LOCK: begin
            if (|(ack & last)) begin
               w_state_nxt = S_IDLE;
               w_gnt_nxt   = '0;
               w_rr_nxt    = w_gidx_inc;
            end else begin
               w_state_nxt = S_LOCK;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   // State, grant and round-robin pointer registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_gnt    <= '0;
         r_gidx   <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_gnt    <= w_gnt_nxt;
         r_gidx   <= w_gidx_nxt;
         r_rr_ptr <= w_rr_nxt;
      end
   end

   // Write-data mux; zero when nobody holds the grant.
   always_comb begin
      w_data = '0;
      for (int i = 0; i < N; i++) begin
         w_data = w_data | (w_data_in[i*B +: B] & {B{r_gnt[i]}});
      end
   end

   assign busy        = (r_state == S_LOCK);
   assign gnt         = r_gnt;
   // gnt is cleared asynchronously, so ack/fifo_wr drop as soon as reset asserts.
   assign ack         = r_gnt & req & {N{~fifo_full}} & {N{busy}};
   assign fifo_wr     = |ack;
   assign fifo_w_data = w_data;

`ifdef FIFO_WR_ARB_BEATCNT_EN
   logic [15:0] r_cnt [N];

   // Accepted-beat counters, wrapping naturally at 16 bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            r_cnt[i] <= 16'd0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
               r_cnt[i] <= r_cnt[i] + 16'd1;
            end else begin
               r_cnt[i] <= r_cnt[i];
            end
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_cnt
      assign beat_cnt[gi*16 +: 16] = r_cnt[gi];
   end
`endif

endmodule
